// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter that commits one requester's word at a time into a
// shared holding register, acknowledging each commit with a one-cycle pulse.
module reg_write_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int CW    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic [WIDTH-1:0]        q,
    output logic                    q_valid,
    output logic [2:0]              owner,
    output logic                    busy,
    output logic [CW-1:0]           commit_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t             state_q;
    logic [2:0]         win_q;
    logic [2:0]         ptr_q;
    logic [NREQ-1:0]    gnt_q;
    logic [NREQ-1:0]    ack_q;
    logic [WIDTH-1:0]   q_q;
    logic               q_valid_q;
    logic [2:0]         owner_q;
    logic [CW-1:0]      cnt_q;

    logic [2*NREQ-1:0]  dbl_s;
    logic [NREQ-1:0]    rot_s;
    logic [2:0]         off_s;
    logic [3:0]         sum_s;
    logic [2:0]         win_s;
    logic               hit_s;
    logic [WIDTH-1:0]   wsel_s;
    logic [2:0]         ptr_next_s;

    function automatic logic [NREQ-1:0] onehot(input logic [2:0] idx);
        logic [NREQ-1:0] oh;
        for (int i = 0; i < NREQ; i++) begin
            oh[i] = (idx == 3'(i));
        end
        return oh;
    endfunction

    // Rotate requests so the pointer position sits at bit 0, then take the lowest set bit.
    always_comb begin
        dbl_s = {req, req} >> ptr_q;
        rot_s = dbl_s[NREQ-1:0];
        off_s = 3'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                off_s = 3'(k);
            end else begin
                off_s = off_s;
            end
        end
        sum_s = {1'b0, ptr_q} + {1'b0, off_s};
        if (sum_s >= 4'(NREQ)) begin
            win_s = 3'(sum_s - 4'(NREQ));
        end else begin
            win_s = sum_s[2:0];
        end
        hit_s = |req;
    end

    // Data slice of the latched winner and the pointer position just past it.
    always_comb begin
        wsel_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_q == 3'(i)) begin
                wsel_s = wdata[i*WIDTH +: WIDTH];
            end else begin
                wsel_s = wsel_s;
            end
        end
        if (win_q == 3'(NREQ - 1)) begin
            ptr_next_s = 3'd0;
        end else begin
            ptr_next_s = win_q + 3'd1;
        end
    end

    // Grant/commit/acknowledge sequencer with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            win_q     <= 3'd0;
            ptr_q     <= 3'd0;
            gnt_q     <= '0;
            ack_q     <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            owner_q   <= 3'd0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en && hit_s) begin
                        win_q   <= win_s;
                        gnt_q   <= onehot(win_s);
                        state_q <= ST_GRANT;
                    end else begin
                        gnt_q   <= '0;
                    end
                end
                ST_GRANT: begin
                    q_q       <= wsel_s;
                    owner_q   <= win_q;
                    q_valid_q <= 1'b1;
                    cnt_q     <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    ack_q     <= onehot(win_q);
                    gnt_q     <= '0;
                    ptr_q     <= ptr_next_s;
                    state_q   <= ST_ACK;
                end
                ST_ACK: begin
                    ack_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    gnt_q   <= '0;
                    ack_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt          = gnt_q;
    assign ack          = ack_q;
    assign q            = q_q;
    assign q_valid      = q_valid_q;
    assign owner        = owner_q;
    assign busy         = (state_q != ST_IDLE);
    assign commit_count = cnt_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized and directed bench for reg_write_arbiter against an edge-by-edge
// reference model of the grant / commit / acknowledge rules.
module tb_reg_write_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int CW    = 4;

    logic                  clk;
    logic                  reset;
    logic                  en;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      q;
    logic                  q_valid;
    logic [2:0]            owner;
    logic                  busy;
    logic [CW-1:0]         commit_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending winner (-1 none), whether the ack cycle is running.
    int              m_pend;
    bit              m_in_ack;
    int              m_ptr;
    logic [7:0]      m_q;
    logic            m_valid;
    int              m_owner;
    int              m_cnt;
    logic [3:0]      m_gnt;
    logic [3:0]      m_ack;

    reg_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .CW(CW)) dut (
        .clk(clk), .reset(reset), .en(en), .req(req), .wdata(wdata),
        .gnt(gnt), .ack(ack), .q(q), .q_valid(q_valid), .owner(owner),
        .busy(busy), .commit_count(commit_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = -1; m_in_ack = 1'b0; m_ptr = 0; m_q = 8'h00; m_valid = 1'b0;
        m_owner = 0; m_cnt = 0; m_gnt = 4'h0; m_ack = 4'h0;
    endtask

    task automatic model_edge();
        int w;
        if (reset) begin
            model_reset();
        end else if (m_in_ack) begin
            m_ack = 4'h0;
            m_in_ack = 1'b0;
        end else if (m_pend >= 0) begin
            m_q      = wdata[m_pend*8 +: 8];
            m_owner  = m_pend;
            m_valid  = 1'b1;
            m_cnt    = (m_cnt + 1) % (1 << CW);
            m_ack    = 4'(1 << m_pend);
            m_gnt    = 4'h0;
            m_ptr    = (m_pend + 1) % NREQ;
            m_pend   = -1;
            m_in_ack = 1'b1;
        end else if (en && (req != 4'h0)) begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
            m_gnt  = 4'(1 << w);
            m_pend = w;
        end else begin
            m_gnt = 4'h0;
        end
    endtask

    task automatic check_all(input string pfx);
        check_val({pfx, ".gnt"},   32'(gnt),          32'(m_gnt));
        check_val({pfx, ".ack"},   32'(ack),          32'(m_ack));
        check_val({pfx, ".q"},     32'(q),            32'(m_q));
        check_val({pfx, ".qv"},    32'(q_valid),      32'(m_valid));
        check_val({pfx, ".owner"}, 32'(owner),        32'(m_owner));
        check_val({pfx, ".busy"},  32'(busy),         32'((m_pend >= 0) || m_in_ack));
        check_val({pfx, ".cnt"},   32'(commit_count), 32'(m_cnt));
    endtask

    task automatic step(input string pfx);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(pfx);
    endtask

    // Assert reset between edges, check it acts immediately, then release after one edge.
    task automatic async_reset(input string pfx);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all({pfx, ".async"});
        step({pfx, ".hold"});
        reset = 1'b0;
    endtask

    int owners[$];
    int qs[$];
    int cyc[$];
    int seq_owner[5] = '{0, 1, 2, 3, 0};
    int seq_q[5]     = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h10};

    initial begin
        reset = 1'b1; en = 1'b0; req = 4'h0; wdata = '0;
        model_reset();
        step("rst0");
        step("rst1");
        reset = 1'b0;

        for (int i = 0; i < 10; i++) step("idle");

        // Single write from requester 2
        en = 1'b1; req = 4'b0100; wdata = 32'h00A5_0000;
        step("sw.e0");
        check_val("sw.gnt", 32'(gnt), 32'h4);
        step("sw.e1");
        check_val("sw.q", 32'(q), 32'hA5);
        check_val("sw.owner", 32'(owner), 32'd2);
        check_val("sw.ack", 32'(ack), 32'h4);
        check_val("sw.cnt", 32'(commit_count), 32'd1);
        req = 4'b0011; wdata = 32'h0000_2211;
        step("sw.e2");
        check_val("sw.ackoff", 32'(ack), 32'h0);
        check_val("sw.busy", 32'(busy), 32'h0);

        // Pointer sits at 3: requester 0 must win before 1
        owners.delete();
        for (int i = 0; i < 7; i++) begin
            step("wrap");
            if (ack != 4'h0) owners.push_back(int'(owner));
        end
        req = 4'h0;
        if (owners.size() >= 2) begin
            check_val("wrap.first", 32'(owners[0]), 32'd0);
            check_val("wrap.second", 32'(owners[1]), 32'd1);
        end else begin
            check_val("wrap.count", 32'(owners.size()), 32'd2);
        end
        step("wrap.end");

        // en gating, then en dropped during GRANT
        en = 1'b0; req = 4'b0001; wdata = 32'h0000_007E;
        for (int i = 0; i < 5; i++) begin
            step("en0");
            check_val("en0.gnt", 32'(gnt), 32'h0);
        end
        en = 1'b1;
        step("en1");
        check_val("en1.gnt", 32'(gnt), 32'h1);
        en = 1'b0;
        step("en1.commit");
        check_val("en1.ack", 32'(ack), 32'h1);
        check_val("en1.q", 32'(q), 32'h7E);
        req = 4'h0;
        step("en1.end");

        // Round-robin fairness from a fresh reset
        async_reset("rr");
        en = 1'b1; req = 4'hF; wdata = 32'h4030_2010;
        owners.delete(); qs.delete(); cyc.delete();
        for (int i = 0; i < 16; i++) begin
            step("rr");
            if (ack != 4'h0) begin
                owners.push_back(int'(owner));
                qs.push_back(int'(q));
                cyc.push_back(i);
            end
        end
        check_val("rr.count", 32'(owners.size() >= 5), 32'd1);
        for (int i = 0; i < 5 && i < owners.size(); i++) begin
            check_val("rr.owner", 32'(owners[i]), 32'(seq_owner[i]));
            check_val("rr.q", 32'(qs[i]), 32'(seq_q[i]));
            if (i > 0) check_val("rr.spacing", 32'(cyc[i] - cyc[i-1]), 32'd3);
        end
        req = 4'h0;
        step("rr.end");
        step("rr.end2");

        // Reset asserted while requester 1 holds the grant
        req = 4'b0010; wdata = 32'h0000_5500;
        step("mg.grant");
        check_val("mg.gnt", 32'(gnt), 32'h2);
        async_reset("mg");
        check_val("mg.q", 32'(q), 32'h0);
        check_val("mg.cnt", 32'(commit_count), 32'h0);
        check_val("mg.ack", 32'(ack), 32'h0);
        req = 4'b0011;
        step("mg.restart");
        check_val("mg.ptr0", 32'(gnt), 32'h1);
        step("mg.commit");
        req = 4'h0;
        step("mg.end");

        // Random traffic, including counter wrap and occasional mid-cycle reset
        for (int i = 0; i < 1500; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            req   = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            wdata = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rnd");
            end else begin
                step("rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Round-robin write arbiter and sequencer for a shared WIDTH-bit holding register with asynchronous reset.
- Up to NREQ requesters each present a request and a data word. The arbiter grants one requester at a time and commits its word to the shared register.
- Each requester receives a one-cycle acknowledge when its word is committed.
- Sits between several producer blocks and a single configuration/data register that they all need to update.

Parameters:
WIDTH, 8, bit width of shared register and each requester's data word
NREQ, 4, number of requesters (2..8)
CW, 16, width of commit counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
en  input  1  arbitration enable; low blocks new grants
req  input  NREQ  per-requester write request, level, bit i = requester i
wdata  input  NREQ*WIDTH  packed data; requester i drives bits [i*WIDTH+WIDTH-1 : i*WIDTH]
gnt  output  NREQ  one-hot grant, registered
ack  output  NREQ  one-hot commit acknowledge, registered, one-cycle pulse
q  output  WIDTH  shared register contents
q_valid  output  1  high once any write has committed since reset
owner  output  3  index of requester whose data is in q
busy  output  1  high when state is not IDLE
commit_count  output  CW  number of commits since reset, wraps modulo 2^CW

Behaviour:
- Reset (asynchronous, active-high; clock clk): state=IDLE, gnt=0, ack=0, q=0, q_valid=0, owner=0, commit_count=0, pointer ptr=0. Takes effect immediately, independent of clk. Any in-flight grant is abandoned and no commit occurs.
- FSM states: IDLE, GRANT, ACK.
- IDLE:
  - If en=1 and req!=0 at an edge: select winner as the first set req bit searching ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
  - On that edge: latch winner index, gnt<=onehot(winner), state<=GRANT.
  - Otherwise remain in IDLE with gnt=0.
- GRANT (exactly 1 cycle), at the next edge:
  - q<=wdata slice of winner, sampled at that edge.
  - owner<=winner, q_valid<=1, commit_count<=commit_count+1.
  - ack<=onehot(winner), gnt<=0.
  - ptr<=winner+1, wrapping NREQ-1 to 0.
  - state<=ACK.
- ACK (exactly 1 cycle): requests are ignored. At the next edge ack<=0 and state<=IDLE.
- Latency and throughput:
  - req seen at edge E0 gives gnt high after E0, then q updated and ack high after E1, then ack low and IDLE after E2.
  - Earliest next arbitration is edge E3. Maximum throughput is one commit per 3 cycles.
- Requester protocol: hold req and wdata stable from assertion until ack is seen; drop req in the ack cycle or later. A requester that keeps req high is treated as a new request at the next IDLE edge.
- Boundary conditions:
  - req dropped while in GRANT: commit still occurs using wdata at the commit edge; ack still pulses. This is a protocol violation with defined behaviour.
  - en deasserted while in GRANT or ACK: the sequence completes. en only gates the IDLE to GRANT transition.
  - Simultaneous requests: exactly one grant. gnt and ack are always one-hot or zero, never multi-hot.
  - Single persistent requester: repeated commits every 3 cycles; ptr advances past it but it wins again because no other request exists.
  - commit_count wraps from 2^CW-1 to 0 with no flag.
  - Reset asserted mid-GRANT: q keeps its reset value 0, no ack is issued, ptr=0.
  - Request bits of index >= NREQ do not exist; owner is zero-extended to 3 bits.
- q holds its value indefinitely between commits. Only the arbiter writes q.

Test Plan:
- Reset and idle: reset pulse mid-cycle with no clk edge -> all outputs 0 immediately; req=0 for 10 cycles -> gnt=0, busy=0, q=0, q_valid=0.
- Single write: req=4'b0100, wdata slice2=8'hA5 at E0 -> gnt=4'b0100 after E0; q=8'hA5, owner=2, ack=4'b0100, q_valid=1, commit_count=1 after E1; ack=0, busy=0 after E2.
- Round-robin fairness: all req=4'b1111 held, each dropping its req in its own ack cycle then reasserting, with slices 8'h10/20/30/40 -> grant order 0,1,2,3,0; q sequence 10,20,30,40,10; commits every 3 cycles.
- Pointer wrap and skip: ptr=3 after granting 2, then req=4'b0011 -> requester 0 granted first, then 1.
- en gating: en=0 with req=4'b0001 for 5 cycles -> no gnt; en=1 -> grant after next edge. en dropped during GRANT -> commit and ack still occur.
- Reset mid-operation: reset asserted while gnt=4'b0010 -> gnt=0, no ack, q=0, commit_count=0. After release, arbitration restarts from ptr=0.
